// File: rtl/trng_source.sv
// Entropy responder: synchronizes a raw ring-oscillator bit, health-tests it,
// von Neumann debiases it and serves conditioned bits from a FIFO on trng_req.
module trng_source #(
  parameter int unsigned FIFO_DEPTH_BITS = 5,
  parameter int unsigned SAMPLE_DIV      = 8,
  parameter int unsigned REP_LIMIT       = 32,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     raw_bit,
  input  logic                     trng_req,
  output logic                     trng_bit,
  output logic                     health_fail,
  output logic                     underrun,
  output logic [FIFO_DEPTH_BITS:0] fill_level
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CW    = FIFO_DEPTH_BITS + 1;

  typedef enum logic {PAIR_EMPTY, PAIR_HALF} pair_state_e;

  logic [SYNC_STAGES-1:0]     sync_q, sync_d;
  logic [7:0]                 div_q, div_d;
  logic                       have_prev_q, have_prev_d;
  logic                       prev_q, prev_d;
  logic [7:0]                 rep_cnt_q, rep_cnt_d;
  pair_state_e                pair_q, pair_d;
  logic                       first_q, first_d;
  logic [DEPTH-1:0]           mem_q, mem_d;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       trng_bit_q, trng_bit_d;
  logic                       health_fail_q, health_fail_d;
  logic                       underrun_q, underrun_d;

  logic raw_s, sample_stb, trip, emit, emit_bit, empty, full, push, pop;

  assign trng_bit    = trng_bit_q;
  assign health_fail = health_fail_q;
  assign underrun    = underrun_q;
  assign fill_level  = count_q;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q        <= '0;
      div_q         <= '0;
      have_prev_q   <= 1'b0;
      prev_q        <= 1'b0;
      rep_cnt_q     <= '0;
      pair_q        <= PAIR_EMPTY;
      first_q       <= 1'b0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      trng_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      div_q         <= div_d;
      have_prev_q   <= have_prev_d;
      prev_q        <= prev_d;
      rep_cnt_q     <= rep_cnt_d;
      pair_q        <= pair_d;
      first_q       <= first_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      trng_bit_q    <= trng_bit_d;
      health_fail_q <= health_fail_d;
      underrun_q    <= underrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], raw_bit};
    raw_s         = sync_q[SYNC_STAGES-1];
    sample_stb    = (div_q == 8'(SAMPLE_DIV - 1));
    div_d         = sample_stb ? 8'd0 : div_q + 8'd1;
    have_prev_d   = have_prev_q;
    prev_d        = prev_q;
    rep_cnt_d     = rep_cnt_q;
    pair_d        = pair_q;
    first_d       = first_q;
    emit          = 1'b0;
    emit_bit      = first_q;

    if (sample_stb) begin
      have_prev_d = 1'b1;
      prev_d      = raw_s;
      if (have_prev_q && (raw_s == prev_q)) begin
        rep_cnt_d = (rep_cnt_q == 8'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + 8'd1;
      end else begin
        rep_cnt_d = 8'd1;
      end
      case (pair_q)
        PAIR_EMPTY: begin
          first_d = raw_s;
          pair_d  = PAIR_HALF;
        end
        default: begin
          pair_d = PAIR_EMPTY;
          emit   = (first_q != raw_s);
        end
      endcase
    end

    // Health trip flushes the FIFO and discards any half-collected pair
    trip          = (rep_cnt_q == 8'(REP_LIMIT)) && !health_fail_q;
    health_fail_d = health_fail_q | trip;
    if (trip) pair_d = PAIR_EMPTY;

    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop      = trng_req && !empty;
    push     = emit && !health_fail_q && !trip && (!full || pop);

    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = emit_bit;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (trip) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    trng_bit_d = trng_bit_q;
    if (trng_req) trng_bit_d = pop ? mem_q[rd_ptr_q] : 1'b0;
    underrun_d = underrun_q | (trng_req && empty);
  end

endmodule

// File: tb/tb_trng_source.sv
// Scoreboard bench for trng_source: stimulus queues expected trng_bit values,
// a negedge monitor compares them whenever a request was presented.
module tb_trng_source;

  logic       clk = 1'b0;
  logic       resetn, raw_bit, trng_req;
  logic       trng_bit, health_fail, underrun;
  logic [5:0] fill_level;

  trng_source #(
    .FIFO_DEPTH_BITS(5), .SAMPLE_DIV(1), .REP_LIMIT(32), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .raw_bit(raw_bit), .trng_req(trng_req),
    .trng_bit(trng_bit), .health_fail(health_fail), .underrun(underrun),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];
  bit model_q[$];
  bit pend_v, pend_b, m_hf, m_under, idle_ph, req_seen;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected response of one request: oldest modelled bit, or 0 on underrun
  task automatic model_pop();
    bit e;
    if (model_q.size() > 0) e = model_q.pop_front();
    else begin
      e = 1'b0;
      m_under = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Two raw samples; an emitted bit lands in the FIFO during the next pair's second cycle
  task automatic pair(bit a, bit b, bit r0, bit r1);
    raw_bit = a; trng_req = r0;
    if (r0) model_pop();
    @(negedge clk);
    raw_bit = b; trng_req = r1;
    if (r1) model_pop();
    if (pend_v && !m_hf && model_q.size() < 32) model_q.push_back(pend_b);
    pend_v = (a != b);
    pend_b = a;
    @(negedge clk);
  endtask

  task automatic data(bit v, bit r0, bit r1);
    pair(v, ~v, r0, r1);
  endtask

  task automatic idle(bit r0, bit r1);
    pair(idle_ph, idle_ph, r0, r1);
    idle_ph = ~idle_ph;
  endtask

  task automatic model_clear();
    model_q.delete();
    pend_v = 1'b0; m_hf = 1'b0; m_under = 1'b0;
  endtask

  task automatic do_reset();
    trng_req = 1'b0; raw_bit = 1'b0; resetn = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    resetn = 1'b1;
  endtask

  always @(posedge clk or negedge resetn)
    if (!resetn) req_seen <= 1'b0;
    else         req_seen <= trng_req;

  // Monitor: one response per request, one cycle later
  always @(negedge clk) begin
    if (req_seen) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard: unexpected response got %0d expected none", trng_bit);
      end else begin
        check("trng_bit", int'(trng_bit), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; raw_bit = 1'b0; trng_req = 1'b0; idle_ph = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_trng_bit", int'(trng_bit), 0);
    check("rst_health", int'(health_fail), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_fill", int'(fill_level), 0);
    resetn = 1'b1;

    // 0,1,1,0 x8 -> 16 bits 0,1,0,1...
    for (int i = 0; i < 8; i++) begin
      data(1'b0, 1'b0, 1'b0);
      data(1'b1, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
    check("t1_fill", int'(fill_level), 16);
    check("t1_health", int'(health_fail), 0);
    check("t1_underrun", int'(underrun), 0);
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("t1_fill_drained", int'(fill_level), 0);
    check("t1_underrun_after", int'(underrun), 0);

    // 0,0,1,1 stream emits nothing; a request underruns
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    check("t2_fill", int'(fill_level), 0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check("t2_underrun", int'(underrun), 1);

    // Fill to 32, overflow pairs dropped, order preserved
    do_reset();
    for (int i = 0; i < 32; i++) data((i % 3) == 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) data(1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t3_fill_full", int'(fill_level), 32);
    check("t3_underrun", int'(underrun), 0);
    for (int i = 0; i < 16; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("t3_fill_drained", int'(fill_level), 0);

    // Full FIFO with a pop coinciding with every push
    for (int i = 0; i < 32; i++) data((i % 4) < 2, 1'b0, 1'b0);
    data(1'b1, 1'b0, 1'b0);
    check("t4_fill_start", int'(fill_level), 32);
    for (int i = 0; i < 7; i++) begin
      data(1'(i % 2), 1'b0, 1'b1);
      check("t4_fill_hold", int'(fill_level), 32);
    end
    idle(1'b0, 1'b1);
    check("t4_fill_end", int'(fill_level), 32);
    for (int i = 0; i < 16; i++) idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("t4_fill_drained", int'(fill_level), 0);
    check("t4_underrun", int'(underrun), 0);

    // Asynchronous reset with a half-collected pair and fill_level=7
    do_reset();
    for (int i = 0; i < 8; i++) data((i % 2) == 0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_fill_pre", int'(fill_level), 7);
    check("t6_bit_pre", int'(trng_bit), 1);
    data(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_bit", int'(trng_bit), 0);
    check("t6_rst_fill", int'(fill_level), 0);
    check("t6_rst_health", int'(health_fail), 0);
    check("t6_rst_underrun", int'(underrun), 0);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    data(1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_fill_fresh", int'(fill_level), 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_fill_post", int'(fill_level), 0);

    // 32 identical samples trip the health test with fill_level=10
    for (int i = 0; i < 10; i++) data(1'(i % 2), 1'b0, 1'b0);
    pair(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_fill_pre", int'(fill_level), 10);
    check("t5_health_pre", int'(health_fail), 0);
    for (int i = 0; i < 16; i++) pair(1'b1, 1'b1, 1'b0, 1'b0);
    pair(1'b0, 1'b0, 1'b0, 1'b0);
    pair(1'b0, 1'b0, 1'b0, 1'b0);
    m_hf = 1'b1;
    model_q.delete();
    check("t5_health", int'(health_fail), 1);
    check("t5_fill_flushed", int'(fill_level), 0);
    for (int i = 0; i < 4; i++) data(1'(i % 2), 1'b0, 1'b0);
    pair(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_fill_blocked", int'(fill_level), 0);
    pair(1'b0, 1'b0, 1'b1, 1'b1);
    pair(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_underrun", int'(underrun), int'(m_under));
    check("t5_health_sticky", int'(health_fail), 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
